// File: rtl/image_spike_sequencer.sv
// Rank-order spike encoder: emits one four-phase AER event per nonzero pixel, brightest first,
// ties in ascending index. Define SPIKE_LIMIT_EN to end early once MAX_OUT_SPIKES output spikes arrive.
module image_spike_sequencer #(
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8,
  parameter int MAX_OUT_SPIKES = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PIX_WR_EN,
  input  logic [7:0]            PIX_WR_ADDR,
  input  logic [PIXEL_BITS-1:0] PIX_WR_DATA,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  AER_IN_REQ,
  output logic [7:0]            AER_IN_ADDR,
  input  logic                  AER_IN_ACK,
  input  logic                  OUT_SPIKE_VLD,
  input  logic [7:0]            OUT_SPIKE_ADDR,
  output logic [7:0]            FIRST_SPIKE_ADDR,
  output logic                  FIRST_SPIKE_VLD,
  output logic [7:0]            OUT_SPIKE_CNT
);
  localparam int                    IW       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [7:0]            LAST_IDX = 8'(IMAGE_SIZE - 1);
  localparam logic [PIXEL_BITS-1:0] T_MAX    = '1;
  localparam logic [PIXEL_BITS-1:0] T_MIN    = PIXEL_BITS'(1);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, ACKLO, FIN} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              i_q, i_d;
  logic [PIXEL_BITS-1:0]   t_q, t_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    req_q, req_d;
  logic [7:0]              addr_q, addr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              first_addr_q, first_addr_d;
  logic                    first_vld_q, first_vld_d;
  logic [PIXEL_BITS-1:0]   pix_q [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0]   pix_cur;
  logic                    pix_we, step, finish, limit_hit;

`ifdef SPIKE_LIMIT_EN
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUT_SPIKES);
  assign limit_hit = (cnt_q >= MAX_CNT);
`else
  assign limit_hit = 1'b0;
`endif

  assign pix_we  = PIX_WR_EN && !busy_q && (PIX_WR_ADDR <= LAST_IDX);
  assign pix_cur = pix_q[i_q[IW-1:0]];

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    t_d          = t_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    req_d        = 1'b0;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    first_addr_d = first_addr_q;
    first_vld_d  = first_vld_q;
    step         = 1'b0;
    finish       = 1'b0;
    unique case (state_q)
      IDLE: if (START) begin
        state_d      = SCAN;
        i_d          = '0;
        t_d          = T_MAX;
        busy_d       = 1'b1;
        cnt_d        = '0;
        first_vld_d  = 1'b0;
        first_addr_d = '0;
      end
      SCAN: begin
        if (limit_hit) finish = 1'b1;
        else if (pix_cur == t_q) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = i_q;
        end else step = 1'b1;
      end
      REQ: begin
        if (AER_IN_ACK) state_d = ACKLO;
        else            req_d   = 1'b1;
      end
      ACKLO: if (!AER_IN_ACK) begin
        if (limit_hit) finish = 1'b1;
        else           step   = 1'b1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // threshold only drops after a full pass; a wrap at T=1 ends the scan so zero pixels never fire
    if (step) begin
      state_d = SCAN;
      if (i_q == LAST_IDX) begin
        i_d = '0;
        if (t_q == T_MIN) finish = 1'b1;
        else              t_d    = t_q - T_MIN;
      end else i_d = i_q + 8'd1;
    end
    if (finish) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (OUT_SPIKE_VLD && busy_q) begin
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (!first_vld_q) begin
        first_vld_d  = 1'b1;
        first_addr_d = OUT_SPIKE_ADDR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      i_q          <= '0;
      t_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      first_addr_q <= '0;
      first_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      t_q          <= t_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      first_addr_q <= first_addr_d;
      first_vld_q  <= first_vld_d;
    end
  end

  // image survives reset so a frame can be re-run without reloading
  always_ff @(posedge CLK) begin
    if (pix_we) pix_q[PIX_WR_ADDR[IW-1:0]] <= PIX_WR_DATA;
  end

  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign AER_IN_REQ       = req_q;
  assign AER_IN_ADDR      = addr_q;
  assign OUT_SPIKE_CNT    = cnt_q;
  assign FIRST_SPIKE_ADDR = first_addr_q;
  assign FIRST_SPIKE_VLD  = first_vld_q;

endmodule
